led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter NCH, default 3, meaning number of LED channels.
REQ-003 SHALL have parameter PWM_W, default 8, meaning PWM counter and duty width in bits.
REQ-004 SHALL have parameter DEB_CYCLES, default 240000, meaning debounce stability window in clocks (10 ms at 24 MHz).
REQ-005 SHALL have port XTAL_IN, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port BTN_A, input, 1 bit: mode button, asynchronous to XTAL_IN, active low.
REQ-008 SHALL have port BTN_B, input, 1 bit: rate button, asynchronous to XTAL_IN, active low.
REQ-009 SHALL have port LED, output, NCH bits: LED drive, active low (0 = lit).
REQ-010 SHALL have port MODE, output, 2 bits: current mode, for status.

Function
REQ-011 SHALL pass each button through a 2-flop synchroniser, both flops resetting to 1.
REQ-012 SHALL debounce each synchronised button with a per-button counter; stable value updates only after DEB_CYCLES consecutive equal samples differing from it; any mismatch clears the counter; glitches shorter than DEB_CYCLES are ignored.
REQ-013 SHALL generate a one-cycle press pulse on each stable 1->0 transition only; release produces no event.
REQ-014 SHALL advance mode by 1 on a BTN_A press, wrapping 3->0: 0 BINARY, 1 CHASE, 2 BREATHE, 3 OFF.
REQ-015 SHALL advance rate (2 bits) by 1 on a BTN_B press, wrapping 3->0; simultaneous A and B presses SHALL both take effect in the same cycle.
REQ-016 SHALL produce a step tick every P = (CLK_HZ/8) >> rate clocks (rate 0 = 8 Hz); the prescaler counts 0..P-1 and ticks at P-1.
REQ-017 SHALL produce a fine tick every PF = P >> PWM_W clocks from a second prescaler.
REQ-018 SHALL clear both prescalers to 0 in the cycle rate changes, so the new period starts immediately.
REQ-019 SHALL size prescalers with $clog2(CLK_HZ/8); PF >= 1 at rate 3 is a parameter constraint, checked by an elaboration-time assertion.
REQ-020 SHALL, on every mode change, reset step counter to 0, one-hot register to 1, and breathe phase to 0 in the same cycle.
REQ-021 BINARY SHALL drive LED = ~step[NCH-1:0], with step incrementing per step tick and wrapping modulo 2^NCH.
REQ-022 CHASE SHALL drive LED = ~onehot, with onehot rotating left by one position per step tick (MSB wraps to bit 0).
REQ-023 BREATHE SHALL keep a PWM_W+1-bit phase incremented per fine tick (wrapping), with duty = phase[PWM_W] ? ~phase[PWM_W-1:0] : phase[PWM_W-1:0].
REQ-024 BREATHE SHALL light all channels while a free-running PWM_W-bit pwm counter is below duty (duty 0 = always off).
REQ-025 OFF SHALL drive LED to all ones; prescalers keep running.
REQ-026 SHALL register LED and MODE outputs: one clock latency from state to pins, with no combinational path from buttons.

Reset
REQ-027 While RST_N is low, SHALL immediately force: mode 0, rate 0, prescalers/step/phase/pwm counter 0, onehot 1, debounce stable 1, debounce counters 0, LED all ones, MODE 0.
REQ-028 Reset assertion mid-operation SHALL abort any pending debounce or tick; operation SHALL resume in BINARY from step 0 on the first clock after release.

Verification (CLK_HZ=16384, NCH=3, PWM_W=4, DEB_CYCLES=4: P0=2048, PF0=128)
REQ-029 Reset release, no buttons -> LED = 111, 110, 101, ... 000, then 111 at tick 8 (every 2048 clocks, wrap).
REQ-030 BTN_A low 3 cycles -> MODE stays 0; BTN_A low 10 cycles then released -> MODE = 1 exactly once, no change on release.
REQ-031 Mode 1 entry -> LED = 110, then 101, 011, 110 on successive ticks.
REQ-032 Three BTN_B presses -> tick period 256 clocks; fourth press -> 2048; prescaler restarts at 0 on each press.
REQ-033 Mode 2 entry -> LED = 111 constantly; after 5 fine ticks LED = 000 for 5 of every 16 clocks; phase 16..31 -> duty falls 15..0.
REQ-034 RST_N pulsed low during mode 1, rate 2 -> LED = 111 and MODE = 0 with no clock edge; after release, binary count restarts with 2048-clock period.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: two debounced buttons select a display mode
// and a step rate; LEDs show binary count, chase, breathe or off.
module led_sequencer #(
  parameter int CLK_HZ     = 24000000,
  parameter int NCH        = 3,
  parameter int PWM_W      = 8,
  parameter int DEB_CYCLES = 240000
) (
  input  logic           XTAL_IN,
  input  logic           RST_N,
  input  logic           BTN_A,
  input  logic           BTN_B,
  output logic [NCH-1:0] LED,
  output logic [1:0]     MODE
);

  localparam int P0 = CLK_HZ / 8;
  localparam int PW = $clog2(P0);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] SM0 = PW'(P0 - 1);
  localparam logic [PW-1:0] SM1 = PW'((P0 >> 1) - 1);
  localparam logic [PW-1:0] SM2 = PW'((P0 >> 2) - 1);
  localparam logic [PW-1:0] SM3 = PW'((P0 >> 3) - 1);

  localparam logic [PW-1:0] FM0 =
    PW'((P0 >> PWM_W) - 1);
  localparam logic [PW-1:0] FM1 =
    PW'(((P0 >> 1) >> PWM_W) - 1);
  localparam logic [PW-1:0] FM2 =
    PW'(((P0 >> 2) >> PWM_W) - 1);
  localparam logic [PW-1:0] FM3 =
    PW'(((P0 >> 3) >> PWM_W) - 1);

  if (((P0 >> 3) >> PWM_W) < 1) begin : g_bad_pf
    $error("fine period is zero at the fastest rate");
  end

  if (NCH < 2) begin : g_bad_nch
    $error("at least two LED channels are needed");
  end

  typedef enum logic [1:0] {
    M_BINARY  = 2'd0,
    M_CHASE   = 2'd1,
    M_BREATHE = 2'd2,
    M_OFF     = 2'd3
  } mode_t;

  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  mode_t         mode_q;
  mode_t         mode_d;
  logic [1:0]    mode_nx;
  logic [1:0]    rate_q;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] fpre_q;
  logic [PW-1:0] step_max;
  logic [PW-1:0] fine_max;
  logic          step_ev;
  logic          fine_ev;

  logic [NCH-1:0]   step_q;
  logic [NCH-1:0]   onehot_q;
  logic [PWM_W:0]   phase_q;
  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W-1:0] duty;
  logic [NCH-1:0]   led_d;

  assign btn = {BTN_B, BTN_A};

  // Press pulse fires with the stable update, only on a falling edge
  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      stable <= 2'b11;
      press  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          stable[i]  <= sync2[i];
          press[i]   <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= M_BINARY;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_nx = mode_q;
    mode_d  = mode_q;
    if (press[0]) begin
      mode_nx = mode_q + 2'd1;
      mode_d  = mode_t'(mode_nx);
    end
  end

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      rate_q <= 2'd0;
    end else if (press[1]) begin
      rate_q <= rate_q + 2'd1;
    end
  end

  always_comb begin
    step_max = SM0;
    fine_max = FM0;
    unique case (rate_q)
      2'd0: begin
        step_max = SM0;
        fine_max = FM0;
      end
      2'd1: begin
        step_max = SM1;
        fine_max = FM1;
      end
      2'd2: begin
        step_max = SM2;
        fine_max = FM2;
      end
      2'd3: begin
        step_max = SM3;
        fine_max = FM3;
      end
      default: begin
        step_max = SM0;
        fine_max = FM0;
      end
    endcase
  end

  // A rate change swallows any tick due in the same cycle
  assign step_ev = (pre_q == step_max) & ~press[1];
  assign fine_ev = (fpre_q == fine_max) & ~press[1];

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      fpre_q <= '0;
    end else if (press[1]) begin
      pre_q  <= '0;
      fpre_q <= '0;
    end else begin
      pre_q  <= step_ev ? '0 : pre_q + 1'b1;
      fpre_q <= fine_ev ? '0 : fpre_q + 1'b1;
    end
  end

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      step_q   <= '0;
      onehot_q <= NCH'(1);
      phase_q  <= '0;
    end else if (press[0]) begin
      step_q   <= '0;
      onehot_q <= NCH'(1);
      phase_q  <= '0;
    end else begin
      if (step_ev) begin
        step_q   <= step_q + 1'b1;
        onehot_q <= {onehot_q[NCH-2:0], onehot_q[NCH-1]};
      end
      if (fine_ev) begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
    end
  end

  // Triangle: ramp up in the low half, down in the high half
  assign duty = phase_q[PWM_W] ? ~phase_q[PWM_W-1:0]
                               : phase_q[PWM_W-1:0];

  always_comb begin
    led_d = '1;
    unique case (mode_q)
      M_BINARY:  led_d = ~step_q;
      M_CHASE:   led_d = ~onehot_q;
      M_BREATHE: led_d = (pwm_q < duty) ? '0 : '1;
      M_OFF:     led_d = '1;
      default:   led_d = '1;
    endcase
  end

  always_ff @(posedge XTAL_IN or negedge RST_N) begin
    if (!RST_N) begin
      LED  <= '1;
      MODE <= 2'd0;
    end else begin
      LED  <= led_d;
      MODE <= mode_q;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at a scaled-down clock:
// P0 = 2048, PF0 = 128, four-cycle debounce.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_a = 1'b1;
  logic       btn_b = 1'b1;
  logic [2:0] led;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_HZ(16384),
    .NCH(3),
    .PWM_W(4),
    .DEB_CYCLES(4)
  ) dut (
    .XTAL_IN(clk),
    .RST_N(rst_n),
    .BTN_A(btn_a),
    .BTN_B(btn_b),
    .LED(led),
    .MODE(mode)
  );

  task automatic wait_change(output int n,
                             output logic [2:0] v);
    logic [2:0] p;
    p = led;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led === p && n < 5000);
    v = led;
  endtask

  task automatic press(input logic a, input logic b);
    btn_a = ~a;
    btn_b = ~b;
    repeat (10) @(negedge clk);
    btn_a = 1'b1;
    btn_b = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic press_time(input logic a, input logic b,
                            output int n);
    logic [2:0] p;
    p = led;
    n = 0;
    btn_a = ~a;
    btn_b = ~b;
    do begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        btn_a = 1'b1;
        btn_b = 1'b1;
      end
    end while (led === p && n < 6000);
    btn_a = 1'b1;
    btn_b = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL rst_led: got %b want 111", led);
    end
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL rst_mode: got %0d want 0", mode);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL rst_led_clk: got %b want 111", led);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_binary();
    int n;
    logic [2:0] v;
    logic [2:0] want;
    wait_change(n, v);
    checks++;
    if (n !== 2049) begin
      errors++;
      $display("FAIL bin_first_n: got %0d want 2049", n);
    end
    checks++;
    if (v !== 3'b110) begin
      errors++;
      $display("FAIL bin_first_v: got %b want 110", v);
    end
    for (int i = 2; i <= 8; i++) begin
      wait_change(n, v);
      want = ~3'(i);
      checks++;
      if (n !== 2048) begin
        errors++;
        $display("FAIL bin_n%0d: got %0d want 2048", i, n);
      end
      checks++;
      if (v !== want) begin
        errors++;
        $display("FAIL bin_v%0d: got %b want %b", i, v, want);
      end
    end
  endtask

  task automatic test_debounce();
    btn_a = 1'b0;
    repeat (3) @(negedge clk);
    btn_a = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL deb_short: got %0d want 0", mode);
    end
    press(1'b1, 1'b0);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL deb_press: got %0d want 1", mode);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL deb_release: got %0d want 1", mode);
    end
  endtask

  task automatic test_chase();
    int n;
    logic [2:0] v;
    logic [2:0] seq [3];
    seq[0] = 3'b101;
    seq[1] = 3'b011;
    seq[2] = 3'b110;
    checks++;
    if (led !== 3'b110) begin
      errors++;
      $display("FAIL chase_entry: got %b want 110", led);
    end
    for (int i = 0; i < 3; i++) begin
      wait_change(n, v);
      checks++;
      if (v !== seq[i]) begin
        errors++;
        $display("FAIL chase_v%0d: got %b want %b",
                 i, v, seq[i]);
      end
      if (i > 0) begin
        checks++;
        if (n !== 2048) begin
          errors++;
          $display("FAIL chase_n%0d: got %0d want 2048", i, n);
        end
      end
    end
  endtask

  task automatic test_rate();
    int n;
    logic [2:0] v;
    int per;
    for (int r = 1; r <= 3; r++) begin
      per = 2048 >> r;
      press_time(1'b0, 1'b1, n);
      checks++;
      if (n !== per + 8) begin
        errors++;
        $display("FAIL rate%0d_restart: got %0d want %0d",
                 r, n, per + 8);
      end
      wait_change(n, v);
      checks++;
      if (n !== per) begin
        errors++;
        $display("FAIL rate%0d_period: got %0d want %0d",
                 r, n, per);
      end
    end
  endtask

  // A and B together: breathe entry and rate 3 -> 0 on one edge
  task automatic test_breathe();
    int n;
    int on0, c5, c15, c16, c20, c31, odd;
    on0 = 0; c5 = 0; c15 = 0; c16 = 0;
    c20 = 0; c31 = 0; odd = 0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    for (n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 10) begin
        btn_a = 1'b1;
        btn_b = 1'b1;
      end
      if (n == 20) begin
        checks++;
        if (mode !== 2'd2) begin
          errors++;
          $display("FAIL br_mode: got %0d want 2", mode);
        end
      end
      if (n >= 8) begin
        if (led !== 3'b000 && led !== 3'b111) odd++;
      end
      if (n >= 8 && n <= 135 && led !== 3'b111) on0++;
      if (n >= 650 && n <= 665 && led === 3'b000) c5++;
      if (n >= 1930 && n <= 1945 && led === 3'b000) c15++;
      if (n >= 2060 && n <= 2075 && led === 3'b000) c16++;
      if (n >= 2570 && n <= 2585 && led === 3'b000) c20++;
      if (n >= 3980 && n <= 3995 && led === 3'b000) c31++;
    end
    checks++;
    if (on0 !== 0) begin
      errors++;
      $display("FAIL br_ph0_lit: got %0d want 0", on0);
    end
    checks++;
    if (odd !== 0) begin
      errors++;
      $display("FAIL br_pattern: got %0d want 0", odd);
    end
    checks++;
    if (c5 !== 5) begin
      errors++;
      $display("FAIL br_ph5: got %0d want 5", c5);
    end
    checks++;
    if (c15 !== 15) begin
      errors++;
      $display("FAIL br_ph15: got %0d want 15", c15);
    end
    checks++;
    if (c16 !== 15) begin
      errors++;
      $display("FAIL br_ph16: got %0d want 15", c16);
    end
    checks++;
    if (c20 !== 11) begin
      errors++;
      $display("FAIL br_ph20: got %0d want 11", c20);
    end
    checks++;
    if (c31 !== 0) begin
      errors++;
      $display("FAIL br_ph31: got %0d want 0", c31);
    end
  endtask

  task automatic test_off_and_wrap();
    int n;
    int lit;
    logic [2:0] v;
    lit = 0;
    press(1'b1, 1'b0);
    checks++;
    if (mode !== 2'd3) begin
      errors++;
      $display("FAIL off_mode: got %0d want 3", mode);
    end
    repeat (300) begin
      @(negedge clk);
      if (led !== 3'b111) lit++;
    end
    checks++;
    if (lit !== 0) begin
      errors++;
      $display("FAIL off_lit: got %0d want 0", lit);
    end
    press(1'b1, 1'b0);
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL wrap_mode: got %0d want 0", mode);
    end
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL wrap_led: got %b want 111", led);
    end
    wait_change(n, v);
    checks++;
    if (v !== 3'b110) begin
      errors++;
      $display("FAIL wrap_v1: got %b want 110", v);
    end
    wait_change(n, v);
    checks++;
    if (n !== 2048) begin
      errors++;
      $display("FAIL wrap_n2: got %0d want 2048", n);
    end
    checks++;
    if (v !== 3'b101) begin
      errors++;
      $display("FAIL wrap_v2: got %b want 101", v);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [2:0] v;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre_mode: got %0d want 1", mode);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL mid_led: got %b want 111", led);
    end
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL mid_mode: got %0d want 0", mode);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_change(n, v);
    checks++;
    if (n !== 2049) begin
      errors++;
      $display("FAIL mid_first_n: got %0d want 2049", n);
    end
    checks++;
    if (v !== 3'b110) begin
      errors++;
      $display("FAIL mid_first_v: got %b want 110", v);
    end
    wait_change(n, v);
    checks++;
    if (n !== 2048) begin
      errors++;
      $display("FAIL mid_n2: got %0d want 2048", n);
    end
    checks++;
    if (v !== 3'b101) begin
      errors++;
      $display("FAIL mid_v2: got %b want 101", v);
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_debounce();
    test_chase();
    test_rate();
    test_breathe();
    test_off_and_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
